// File: rtl/icache_refill_engine.sv
// I-cache miss refill engine: turns a line miss into LINE_WORDS single-word reads
// (or one uncached read for the MMIO window) and returns the assembled line.
module icache_refill_engine #(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       l1_mmu_req_read,
  input  logic [31:0]                l1_mmu_req_addr,
  output logic                       mmu_l1_done,
  output logic [LINE_WORDS*32-1:0]   mmu_l1_read_data,
  output logic                       mem_rd_valid,
  input  logic                       mem_rd_ready,
  output logic [31:0]                mem_rd_addr,
  input  logic                       mem_resp_valid,
  input  logic [31:0]                mem_resp_data,
  output logic                       busy
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = BEAT_W + 2;
  localparam int unsigned TAG_W  = 32 - OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                    state;
  logic [TAG_W-1:0]          req_line;
  logic                      req_mmio;
  logic                      stale;
  logic [BEAT_W-1:0]         beat;
  logic [LINE_WORDS*32-1:0]  line_buf;

  logic                      addr_mmio;
  logic                      stale_now;
  logic                      stale_any;
  logic [BEAT_W-1:0]         beat_inc;
  logic                      unused_addr_lsbs;

  assign addr_mmio        = (l1_mmu_req_addr[31:16] == MMIO_BASE[31:16]);
  // The requester no longer wants what is being fetched: dropped, moved line, or changed class.
  assign stale_now        = !l1_mmu_req_read
                         || (l1_mmu_req_addr[31:OFF_W] != req_line)
                         || (addr_mmio != req_mmio);
  assign stale_any        = stale || stale_now;
  assign beat_inc         = beat + 1'b1;
  assign mmu_l1_read_data = line_buf;
  assign unused_addr_lsbs = ^l1_mmu_req_addr[1:0];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_line     <= '0;
      req_mmio     <= 1'b0;
      stale        <= 1'b0;
      beat         <= '0;
      line_buf     <= '0;
      mmu_l1_done  <= 1'b0;
      mem_rd_valid <= 1'b0;
      mem_rd_addr  <= '0;
      busy         <= 1'b0;
    end else begin
      mmu_l1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (l1_mmu_req_read) begin
            req_line     <= l1_mmu_req_addr[31:OFF_W];
            req_mmio     <= addr_mmio;
            stale        <= 1'b0;
            beat         <= '0;
            mem_rd_valid <= 1'b1;
            mem_rd_addr  <= addr_mmio ? {l1_mmu_req_addr[31:2], 2'b00}
                                      : {l1_mmu_req_addr[31:OFF_W], {OFF_W{1'b0}}};
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          stale <= stale_any;
          // An accepted address always owes a response, so a handshake wins over abort.
          if (mem_rd_ready) begin
            mem_rd_valid <= 1'b0;
            state        <= WAIT;
          end else if (stale_any) begin
            mem_rd_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        WAIT: begin
          stale <= stale_any;
          if (mem_resp_valid) begin
            if (stale_any) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              if (req_mmio) begin
                line_buf <= (LINE_WORDS*32)'(mem_resp_data);
              end else begin
                line_buf[beat*32 +: 32] <= mem_resp_data;
              end
              if (req_mmio || beat == LAST_BEAT) begin
                mmu_l1_done <= 1'b1;
                state       <= DONE;
              end else begin
                beat         <= beat_inc;
                mem_rd_valid <= 1'b1;
                mem_rd_addr  <= {req_line, beat_inc, 2'b00};
                state        <= ISSUE;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_rd_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_engine.sv
// Bench for icache_refill_engine: a reactive memory model with configurable stalls and
// response delays, plus a line-level reference model of what each fill must produce.
module tb_icache_refill_engine;

  logic         sys_clk;
  logic         rst_n;
  logic         l1_mmu_req_read;
  logic [31:0]  l1_mmu_req_addr;
  logic         mmu_l1_done;
  logic [255:0] mmu_l1_read_data;
  logic         mem_rd_valid;
  logic         mem_rd_ready;
  logic [31:0]  mem_rd_addr;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_data;
  logic         busy;

  icache_refill_engine #(.LINE_WORDS(8), .MMIO_BASE(32'hFFFF0000)) dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .l1_mmu_req_read  (l1_mmu_req_read),
    .l1_mmu_req_addr  (l1_mmu_req_addr),
    .mmu_l1_done      (mmu_l1_done),
    .mmu_l1_read_data (mmu_l1_read_data),
    .mem_rd_valid     (mem_rd_valid),
    .mem_rd_ready     (mem_rd_ready),
    .mem_rd_addr      (mem_rd_addr),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_data    (mem_resp_data),
    .busy             (busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] hs_q[$];
  int          done_cnt     = 0;
  int          unstable_cnt = 0;
  int          stall_max    = 0;
  int          dly_min      = 1;
  int          dly_max      = 1;

  // Reference memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hFFFF_0010) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_5A3C;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:16] == 16'hFFFF;
  endfunction

  // i-th address a fill for request a must put on the bus
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int i);
    if (is_mmio(a)) return {a[31:2], 2'b00};
    return {a[31:5], 5'b0} + 32'(4 * i);
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    logic [255:0] l;
    if (is_mmio(a)) return {224'b0, mem_word({a[31:2], 2'b00})};
    for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_word(exp_addr(a, i));
    return l;
  endfunction

  // Memory slave: samples at negedge, drives 1 ns after posedge
  initial begin : mem_model
    int          countdown;
    int          stall_left;
    bit          took;
    bit          prev_stall;
    logic [31:0] prev_addr;
    logic [31:0] pend_addr;
    countdown = 0; stall_left = 0; prev_stall = 1'b0; prev_addr = '0; pend_addr = '0;
    mem_rd_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(negedge sys_clk);
      took = 1'b0;
      if (mmu_l1_done === 1'b1) done_cnt++;
      if (prev_stall && mem_rd_valid && mem_rd_addr !== prev_addr) unstable_cnt++;
      prev_stall = mem_rd_valid && !mem_rd_ready;
      prev_addr  = mem_rd_addr;
      if (mem_rd_valid && !mem_rd_ready && stall_left > 0) stall_left--;
      if (mem_rd_valid && mem_rd_ready && rst_n) begin
        hs_q.push_back(mem_rd_addr);
        pend_addr = mem_rd_addr;
        countdown = $urandom_range(dly_max, dly_min);
        took = 1'b1;
      end
      @(posedge sys_clk);
      #1;
      mem_resp_valid = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_word(pend_addr);
        end
      end
      if (took) stall_left = $urandom_range(stall_max, 0);
      mem_rd_ready = (stall_left == 0);
    end
  end

  task automatic do_request(input logic [31:0] a, input int budget, output int cycles, output bit ok);
    @(posedge sys_clk);
    #1;
    l1_mmu_req_read = 1'b1;
    l1_mmu_req_addr = a;
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget) begin
      @(negedge sys_clk);
      cycles++;
      if (mmu_l1_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_req();
    @(posedge sys_clk);
    #1;
    l1_mmu_req_read = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    l1_mmu_req_read = 1'b0;
    l1_mmu_req_addr = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    tests_run++;
    if (mmu_l1_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b, expected 0", mmu_l1_done); end
    tests_run++;
    if (mem_rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, expected 0", mem_rd_valid); end
    tests_run++;
    if (mem_rd_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h, expected 0", mem_rd_addr); end
    tests_run++;
    if (mmu_l1_read_data !== 256'h0) begin tests_failed++; $display("FAIL reset_data: got %h, expected 0", mmu_l1_read_data); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    @(posedge sys_clk);
    #3 rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    tests_run++;
    if (busy !== 1'b0 || mem_rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release_idle: busy=%b valid=%b, expected 0 0", busy, mem_rd_valid);
    end
  endtask

  task automatic test_line_fill();
    int cycles;
    bit ok;
    int d0;
    stall_max = 0; dly_min = 1; dly_max = 1;
    hs_q.delete();
    d0 = done_cnt;
    do_request(32'h0000_1234, 40, cycles, ok);
    tests_run++;
    if (!ok || cycles != 18) begin tests_failed++; $display("FAIL fill_latency: got %0d (done=%b), expected 18", cycles, ok); end
    tests_run++;
    if (mmu_l1_read_data[31:0] !== mem_word(32'h1220)) begin
      tests_failed++; $display("FAIL fill_word0: got %h, expected %h", mmu_l1_read_data[31:0], mem_word(32'h1220));
    end
    tests_run++;
    if (mmu_l1_read_data[255:224] !== mem_word(32'h123C)) begin
      tests_failed++; $display("FAIL fill_word7: got %h, expected %h", mmu_l1_read_data[255:224], mem_word(32'h123C));
    end
    tests_run++;
    if (mmu_l1_read_data !== exp_line(32'h1234)) begin
      tests_failed++; $display("FAIL fill_line: got %h, expected %h", mmu_l1_read_data, exp_line(32'h1234));
    end
    tests_run++;
    if (hs_q.size() != 8) begin tests_failed++; $display("FAIL fill_hs_count: got %0d, expected 8", hs_q.size()); end
    for (int i = 0; i < hs_q.size(); i++) begin
      tests_run++;
      if (hs_q[i] !== exp_addr(32'h1234, i)) begin
        tests_failed++; $display("FAIL fill_addr%0d: got %h, expected %h", i, hs_q[i], exp_addr(32'h1234, i));
      end
    end
    release_req();
    repeat (4) @(posedge sys_clk);
    #2;
    tests_run++;
    if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL fill_done_pulses: got %0d, expected 1", done_cnt - d0); end
    tests_run++;
    if (mmu_l1_read_data !== exp_line(32'h1234)) begin
      tests_failed++; $display("FAIL fill_data_hold: got %h, expected %h", mmu_l1_read_data, exp_line(32'h1234));
    end
  endtask

  task automatic test_mmio();
    int cycles;
    bit ok;
    stall_max = 0; dly_min = 1; dly_max = 1;
    hs_q.delete();
    do_request(32'hFFFF_0010, 20, cycles, ok);
    tests_run++;
    if (!ok || cycles != 4) begin tests_failed++; $display("FAIL mmio_latency: got %0d (done=%b), expected 4", cycles, ok); end
    tests_run++;
    if (mmu_l1_read_data !== {224'b0, 32'hDEAD_BEEF}) begin
      tests_failed++; $display("FAIL mmio_data: got %h, expected %h", mmu_l1_read_data, {224'b0, 32'hDEAD_BEEF});
    end
    release_req();
    repeat (3) @(posedge sys_clk);
    #2;
    tests_run++;
    if (hs_q.size() != 1 || hs_q[0] !== 32'hFFFF_0010) begin
      tests_failed++; $display("FAIL mmio_hs: got %0d reads first %h, expected 1 read at ffff0010", hs_q.size(), hs_q.size() > 0 ? hs_q[0] : 32'h0);
    end
  endtask

  task automatic test_random_stalls();
    int          cycles;
    bit          ok;
    int          n_exp;
    logic [31:0] a;
    stall_max = 5; dly_min = 1; dly_max = 4;
    unstable_cnt = 0;
    for (int it = 0; it < 6; it++) begin
      a = $urandom;
      if (it == 2) a = {16'hFFFF, 16'($urandom)};
      else if (is_mmio(a)) a[31] = 1'b0;
      n_exp = is_mmio(a) ? 1 : 8;
      hs_q.delete();
      do_request(a, 400, cycles, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL rand_timeout: addr %h, no done in %0d cycles", a, cycles); end
      tests_run++;
      if (mmu_l1_read_data !== exp_line(a)) begin
        tests_failed++; $display("FAIL rand_line: addr %h got %h, expected %h", a, mmu_l1_read_data, exp_line(a));
      end
      release_req();
      repeat (2) @(posedge sys_clk);
      #2;
      tests_run++;
      if (hs_q.size() != n_exp) begin tests_failed++; $display("FAIL rand_hs_count: got %0d, expected %0d", hs_q.size(), n_exp); end
      for (int i = 0; i < hs_q.size(); i++) begin
        tests_run++;
        if (hs_q[i] !== exp_addr(a, i)) begin
          tests_failed++; $display("FAIL rand_addr%0d: got %h, expected %h", i, hs_q[i], exp_addr(a, i));
        end
      end
    end
    tests_run++;
    if (unstable_cnt != 0) begin tests_failed++; $display("FAIL rand_addr_stable: %0d changes while stalled, expected 0", unstable_cnt); end
    stall_max = 0; dly_min = 1; dly_max = 1;
    repeat (8) @(posedge sys_clk);
  endtask

  task automatic test_back_to_back();
    int cycles;
    bit ok;
    int d0;
    stall_max = 0; dly_min = 1; dly_max = 1;
    hs_q.delete();
    d0 = done_cnt;
    do_request(32'h0000_6000, 40, cycles, ok);
    do_request(32'h0000_7040, 40, cycles, ok);
    tests_run++;
    if (!ok || cycles != 18) begin tests_failed++; $display("FAIL b2b_latency: got %0d (done=%b), expected 18", cycles, ok); end
    tests_run++;
    if (mmu_l1_read_data !== exp_line(32'h7040)) begin
      tests_failed++; $display("FAIL b2b_line: got %h, expected %h", mmu_l1_read_data, exp_line(32'h7040));
    end
    do_request(32'h0000_7040, 40, cycles, ok);
    tests_run++;
    if (!ok || cycles != 18) begin tests_failed++; $display("FAIL b2b_same_line: got %0d (done=%b), expected 18", cycles, ok); end
    release_req();
    repeat (3) @(posedge sys_clk);
    #2;
    tests_run++;
    if (done_cnt - d0 != 3 || hs_q.size() != 24) begin
      tests_failed++; $display("FAIL b2b_counts: got %0d done %0d reads, expected 3 done 24 reads", done_cnt - d0, hs_q.size());
    end
  endtask

  task automatic test_drop_mid_fill();
    int cycles;
    bit ok;
    int d0;
    stall_max = 0; dly_min = 3; dly_max = 3;
    hs_q.delete();
    d0 = done_cnt;
    @(posedge sys_clk);
    #1;
    l1_mmu_req_read = 1'b1;
    l1_mmu_req_addr = 32'h0000_1220;
    for (int c = 0; c < 100; c++) begin
      @(posedge sys_clk);
      #2;
      if (hs_q.size() >= 4) break;
    end
    tests_run++;
    if (hs_q.size() != 4) begin tests_failed++; $display("FAIL drop_reach_beat3: got %0d reads, expected 4", hs_q.size()); end
    l1_mmu_req_read = 1'b0;
    @(negedge sys_clk);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL drop_waits_resp: busy=%b, expected 1", busy); end
    repeat (12) @(posedge sys_clk);
    #2;
    tests_run++;
    if (hs_q.size() != 4) begin tests_failed++; $display("FAIL drop_no_more_reads: got %0d, expected 4", hs_q.size()); end
    tests_run++;
    if (done_cnt != d0) begin tests_failed++; $display("FAIL drop_no_done: got %0d pulses, expected 0", done_cnt - d0); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL drop_idle: busy=%b, expected 0", busy); end
    dly_min = 1; dly_max = 2;
    hs_q.delete();
    do_request(32'h0000_2000, 100, cycles, ok);
    tests_run++;
    if (!ok || mmu_l1_read_data !== exp_line(32'h2000)) begin
      tests_failed++; $display("FAIL drop_refill: done=%b got %h, expected %h", ok, mmu_l1_read_data, exp_line(32'h2000));
    end
    release_req();
    repeat (2) @(posedge sys_clk);
    #2;
    tests_run++;
    if (hs_q.size() != 8 || hs_q[0] !== 32'h2000) begin
      tests_failed++; $display("FAIL drop_refill_hs: got %0d reads, expected 8 from 00002000", hs_q.size());
    end
  endtask

  task automatic test_line_change();
    int cycles;
    bit ok;
    int d0;
    int bad;
    stall_max = 0; dly_min = 2; dly_max = 2;
    hs_q.delete();
    d0 = done_cnt;
    @(posedge sys_clk);
    #1;
    l1_mmu_req_read = 1'b1;
    l1_mmu_req_addr = 32'h0000_1220;
    for (int c = 0; c < 100; c++) begin
      @(posedge sys_clk);
      #2;
      if (hs_q.size() >= 6) break;
    end
    l1_mmu_req_addr = 32'h0000_3000;
    ok = 1'b0;
    cycles = 0;
    while (cycles < 100) begin
      @(negedge sys_clk);
      cycles++;
      if (mmu_l1_done === 1'b1) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL chg_timeout: no done in %0d cycles", cycles); end
    tests_run++;
    if (mmu_l1_read_data !== exp_line(32'h3000)) begin
      tests_failed++; $display("FAIL chg_line: got %h, expected %h", mmu_l1_read_data, exp_line(32'h3000));
    end
    release_req();
    repeat (3) @(posedge sys_clk);
    #2;
    tests_run++;
    if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL chg_done_pulses: got %0d, expected 1", done_cnt - d0); end
    tests_run++;
    if (hs_q.size() != 14) begin tests_failed++; $display("FAIL chg_hs_count: got %0d, expected 14", hs_q.size()); end
    bad = 0;
    for (int i = 0; i < hs_q.size(); i++) begin
      if (i < 6 && hs_q[i] !== exp_addr(32'h1220, i)) bad++;
      if (i >= 6 && hs_q[i] !== exp_addr(32'h3000, i - 6)) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL chg_addr_seq: got %0d wrong addresses, expected 0", bad); end
  endtask

  task automatic test_reset_mid_wait();
    int cycles;
    bit ok;
    stall_max = 0; dly_min = 4; dly_max = 4;
    hs_q.delete();
    @(posedge sys_clk);
    #1;
    l1_mmu_req_read = 1'b1;
    l1_mmu_req_addr = 32'h0000_4000;
    for (int c = 0; c < 100; c++) begin
      @(posedge sys_clk);
      #2;
      if (hs_q.size() >= 2) break;
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (mem_rd_valid !== 1'b0 || mem_rd_addr !== 32'h0) begin
      tests_failed++; $display("FAIL rst_async_bus: valid=%b addr=%h, expected 0 0", mem_rd_valid, mem_rd_addr);
    end
    tests_run++;
    if (busy !== 1'b0 || mmu_l1_done !== 1'b0) begin
      tests_failed++; $display("FAIL rst_async_ctrl: busy=%b done=%b, expected 0 0", busy, mmu_l1_done);
    end
    tests_run++;
    if (mmu_l1_read_data !== 256'h0) begin tests_failed++; $display("FAIL rst_async_data: got %h, expected 0", mmu_l1_read_data); end
    l1_mmu_req_read = 1'b0;
    @(posedge sys_clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    tests_run++;
    if (mmu_l1_read_data !== 256'h0 || busy !== 1'b0 || mem_rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rst_late_resp: data=%h busy=%b valid=%b, expected 0 0 0", mmu_l1_read_data, busy, mem_rd_valid);
    end
    dly_min = 1; dly_max = 3;
    hs_q.delete();
    do_request(32'h0000_5000, 120, cycles, ok);
    tests_run++;
    if (!ok || mmu_l1_read_data !== exp_line(32'h5000)) begin
      tests_failed++; $display("FAIL rst_refill: done=%b got %h, expected %h", ok, mmu_l1_read_data, exp_line(32'h5000));
    end
    release_req();
    repeat (2) @(posedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_line_fill();
    test_mmio();
    test_back_to_back();
    test_random_stalls();
    test_drop_mid_fill();
    test_line_change();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
